ddr3_dfi_wrdata_sched: RTL and testbench

Parametrised DDR3 DFI write-data scheduler: queues accepted write commands and their burst data, then after a programmable write latency serialises each burst onto the DFI write-data lanes. Each burst drives either the full burst length or a per-command partial beat count. Sits between the DDR3 command sequencer (which issues WRITE on the DFI command bus and pushes the matching data here in the same cycle) and the DFI PHY write-data interface. Generalises the single-timer partial-write control to multiple in-flight writes, configurable widths and latency, and defined collision handling.

---
 rtl/ddr3_dfi_wrdata_sched.sv | 205 ++++++++++++++++++++
 tb/tb_ddr3_dfi_wrdata_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_dfi_wrdata_sched.sv
// DDR3 DFI write-data scheduler: queues write bursts and streams them
// onto the DFI write-data lanes after a fixed write latency.
module ddr3_dfi_wrdata_sched #(
  parameter int DFI_DATA_W    = 32,
  parameter int BURST_BEATS   = 8,
  parameter int WRITE_LATENCY = 4,
  parameter int DEPTH         = 4,
  parameter int BEAT_W        = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                wr_valid_i,
  output logic                                wr_ready_o,
  input  logic [DFI_DATA_W*BURST_BEATS-1:0]   wr_data_i,
  input  logic [DFI_DATA_W/8*BURST_BEATS-1:0] wr_mask_i,
  input  logic                                wr_partial_i,
  input  logic [BEAT_W-1:0]                   wr_beats_i,
  output logic [DFI_DATA_W-1:0]               dfi_wrdata_o,
  output logic                                dfi_wrdata_en_o,
  output logic [DFI_DATA_W/8-1:0]             dfi_wrdata_mask_o,
  output logic [$clog2(DEPTH+1)-1:0]          pending_o,
  output logic                                busy_o,
  output logic                                late_o,
  output logic                                param_err_o
);

  localparam int HW = DFI_DATA_W * BURST_BEATS;
  localparam int MW = DFI_DATA_W / 8;
  localparam int HM = MW * BURST_BEATS;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = $clog2(BURST_BEATS + 1);
  localparam int LW = 4;
  // Countdown hits 0 in the cycle whose edge launches beat 0.
  localparam logic [LW-1:0] LOAD =
    LW'((WRITE_LATENCY >= 2) ? WRITE_LATENCY - 2 : 0);
  localparam bit BYPASS = (WRITE_LATENCY == 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [HW-1:0]    q_data  [DEPTH];
  logic [HM-1:0]    q_mask  [DEPTH];
  logic [EW-1:0]    q_beats [DEPTH];
  logic [LW-1:0]    q_cd    [DEPTH];
  logic [DEPTH-1:0] q_late;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] pend;
  logic [CW-1:0] pend_n;
  logic          ready_q;

  logic [0:0]      state;
  logic [EW-1:0]   rem;
  logic [HW-1:0]   sdata;
  logic [HM-1:0]   smask;
  logic [DFI_DATA_W-1:0] dout;
  logic [MW-1:0]   mout;
  logic            en_q;
  logic            late_q;
  logic            perr_q;
  logic            busy_q;

  logic          acc;
  logic          clamp;
  logic [EW-1:0] e_in;
  logic          head_due;
  logic          stream_more;
  logic          free;
  logic          byp;
  logic          start;
  logic          push;
  logic          pop;
  logic [HW-1:0] src_data;
  logic [HM-1:0] src_mask;
  logic [EW-1:0] src_beats;
  logic          src_late;

  always_comb begin
    acc   = wr_valid_i && ready_q;
    clamp = wr_partial_i &&
            ((wr_beats_i == '0) || (32'(wr_beats_i) > BURST_BEATS));
    e_in  = EW'(BURST_BEATS);
    if (wr_partial_i) begin
      if (wr_beats_i == '0)
        e_in = EW'(1);
      else if (32'(wr_beats_i) <= BURST_BEATS)
        e_in = EW'(wr_beats_i);
    end

    head_due    = (pend != '0) && (q_cd[rd_ptr] == '0);
    stream_more = (state == STREAM) && (rem != '0);
    free        = !stream_more;
    // Latency 1 needs the accepted burst on the lanes at the accept edge.
    byp         = BYPASS && acc && (pend == '0) && free;
    pop         = free && head_due;
    start       = pop || byp;
    push        = acc && !byp;

    src_data  = q_data[rd_ptr];
    src_mask  = q_mask[rd_ptr];
    src_beats = q_beats[rd_ptr];
    src_late  = q_late[rd_ptr];
    if (byp) begin
      src_data  = wr_data_i;
      src_mask  = wr_mask_i;
      src_beats = e_in;
      src_late  = 1'b0;
    end

    unique case ({push, pop})
      2'b10:   pend_n = pend + CW'(1);
      2'b01:   pend_n = pend - CW'(1);
      default: pend_n = pend;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_data[wr_ptr]  <= wr_data_i;
      q_mask[wr_ptr]  <= wr_mask_i;
      q_beats[wr_ptr] <= e_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) q_cd[i] <= '0;
      q_late  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pend    <= '0;
      ready_q <= 1'b1;
    end else begin
      // A slot still waiting once its countdown is 0 has missed its slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (q_cd[i] != '0) q_cd[i] <= q_cd[i] - LW'(1);
        if (q_cd[i] == '0) q_late[i] <= 1'b1;
      end
      if (push) begin
        q_cd[wr_ptr]   <= LOAD;
        q_late[wr_ptr] <= BYPASS;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      pend    <= pend_n;
      ready_q <= (pend_n != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      rem    <= '0;
      sdata  <= '0;
      smask  <= '0;
      dout   <= '0;
      mout   <= '0;
      en_q   <= 1'b0;
      late_q <= 1'b0;
      perr_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      perr_q <= acc && clamp;
      late_q <= start && src_late;
      busy_q <= (pend_n != '0) || start || stream_more;
      unique case (1'b1)
        start: begin
          state <= STREAM;
          rem   <= src_beats - EW'(1);
          dout  <= src_data[DFI_DATA_W-1:0];
          mout  <= src_mask[MW-1:0];
          sdata <= src_data >> DFI_DATA_W;
          smask <= src_mask >> MW;
          en_q  <= 1'b1;
        end
        stream_more: begin
          rem   <= rem - EW'(1);
          dout  <= sdata[DFI_DATA_W-1:0];
          mout  <= smask[MW-1:0];
          sdata <= sdata >> DFI_DATA_W;
          smask <= smask >> MW;
          en_q  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          dout  <= '0;
          mout  <= '0;
          en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready_o        = ready_q;
  assign dfi_wrdata_o      = dout;
  assign dfi_wrdata_en_o   = en_q;
  assign dfi_wrdata_mask_o = mout;
  assign pending_o         = pend;
  assign busy_o            = busy_q;
  assign late_o            = late_q;
  assign param_err_o       = perr_q;

endmodule

// File: tb/tb_ddr3_dfi_wrdata_sched.sv
// Directed bench for ddr3_dfi_wrdata_sched: burst timing, partial
// and clamped bursts, collisions, backpressure and mid-burst reset.
module tb_ddr3_dfi_wrdata_sched;

  localparam int DW = 32;
  localparam int BB = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic          wr_ready_o;
  logic [DW*BB-1:0]   wr_data_i = '0;
  logic [DW/8*BB-1:0] wr_mask_i = '0;
  logic          wr_partial_i = 1'b0;
  logic [3:0]    wr_beats_i = '0;
  logic [DW-1:0] dfi_wrdata_o;
  logic          dfi_wrdata_en_o;
  logic [3:0]    dfi_wrdata_mask_o;
  logic [2:0]    pending_o;
  logic          busy_o;
  logic          late_o;
  logic          param_err_o;

  int ncmp = 0;
  int nerr = 0;

  ddr3_dfi_wrdata_sched #(
    .DFI_DATA_W(DW), .BURST_BEATS(BB), .WRITE_LATENCY(4),
    .DEPTH(4), .BEAT_W(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_data_i(wr_data_i), .wr_mask_i(wr_mask_i),
    .wr_partial_i(wr_partial_i), .wr_beats_i(wr_beats_i),
    .dfi_wrdata_o(dfi_wrdata_o), .dfi_wrdata_en_o(dfi_wrdata_en_o),
    .dfi_wrdata_mask_o(dfi_wrdata_mask_o), .pending_o(pending_o),
    .busy_o(busy_o), .late_o(late_o), .param_err_o(param_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic part, input logic [3:0] nb,
                      input logic [31:0] base, input logic msk);
    wr_valid_i   = 1'b1;
    wr_partial_i = part;
    wr_beats_i   = nb;
    for (int k = 0; k < BB; k++) begin
      wr_data_i[k*DW +: DW] = base + 32'(k);
      wr_mask_i[k*4 +: 4]   = msk ? 4'(k + 1) : 4'h0;
    end
  endtask

  task automatic expect_burst(input string tag, input int n,
                              input logic [31:0] base,
                              input logic first_late, input logic msk);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_en"}, 64'(dfi_wrdata_en_o), 64'(1));
      chk({tag, "_data"}, 64'(dfi_wrdata_o), 64'(base + 32'(k)));
      chk({tag, "_mask"}, 64'(dfi_wrdata_mask_o),
          64'(msk ? 4'(k + 1) : 4'h0));
      chk({tag, "_late"}, 64'(late_o),
          64'((k == 0) ? first_late : 1'b0));
      tick();
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_idle_en"}, 64'(dfi_wrdata_en_o), 64'(0));
    chk({tag, "_idle_data"}, 64'(dfi_wrdata_o), 64'(0));
    chk({tag, "_idle_mask"}, 64'(dfi_wrdata_mask_o), 64'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    tick();
    chk("rst_ready", 64'(wr_ready_o), 64'(1));
    chk("rst_pend", 64'(pending_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_late", 64'(late_o), 64'(0));
    chk("rst_perr", 64'(param_err_o), 64'(0));
    expect_idle("rst");

    // full burst, beats at T+4..T+11
    send(1'b0, 4'd0, 32'h1000_0000, 1'b0);
    tick();
    wr_valid_i = 1'b0;
    chk("full_pend", 64'(pending_o), 64'(1));
    chk("full_busy", 64'(busy_o), 64'(1));
    chk("full_perr", 64'(param_err_o), 64'(0));
    chk("full_en_t1", 64'(dfi_wrdata_en_o), 64'(0));
    tick();
    tick();
    chk("full_en_t3", 64'(dfi_wrdata_en_o), 64'(0));
    tick();
    expect_burst("full", 8, 32'h1000_0000, 1'b0, 1'b0);
    expect_idle("full");
    chk("full_busy_end", 64'(busy_o), 64'(0));
    chk("full_pend_end", 64'(pending_o), 64'(0));

    // partial 3 beats with a mask pattern
    send(1'b1, 4'd3, 32'h2000_0000, 1'b1);
    tick();
    wr_valid_i = 1'b0;
    chk("part_perr", 64'(param_err_o), 64'(0));
    tick();
    tick();
    tick();
    expect_burst("part", 3, 32'h2000_0000, 1'b0, 1'b1);
    expect_idle("part");

    // clamp beats=0 to one beat
    send(1'b1, 4'd0, 32'h3000_0000, 1'b0);
    tick();
    wr_valid_i = 1'b0;
    chk("clamp0_perr", 64'(param_err_o), 64'(1));
    tick();
    chk("clamp0_perr_off", 64'(param_err_o), 64'(0));
    tick();
    tick();
    expect_burst("clamp0", 1, 32'h3000_0000, 1'b0, 1'b0);
    expect_idle("clamp0");

    // clamp beats=12 to a full burst
    send(1'b1, 4'd12, 32'h3100_0000, 1'b0);
    tick();
    wr_valid_i = 1'b0;
    chk("clamp12_perr", 64'(param_err_o), 64'(1));
    tick();
    chk("clamp12_perr_off", 64'(param_err_o), 64'(0));
    tick();
    tick();
    expect_burst("clamp12", 8, 32'h3100_0000, 1'b0, 1'b0);
    expect_idle("clamp12");

    // collision: second burst due T+7, lands T+12 with late
    send(1'b0, 4'd0, 32'h4000_0000, 1'b0);
    tick();
    wr_valid_i = 1'b0;
    tick();
    tick();
    send(1'b1, 4'd2, 32'h5000_0000, 1'b0);
    tick();
    wr_valid_i = 1'b0;
    expect_burst("coll_a", 8, 32'h4000_0000, 1'b0, 1'b0);
    expect_burst("coll_b", 2, 32'h5000_0000, 1'b1, 1'b0);
    expect_idle("coll");

    // backpressure: six full bursts, the sixth held until ready
    for (int c = 0; c < 53; c++) begin
      if (c < 5)
        send(1'b0, 4'd0, 32'h8000_0000 + 32'(c * 256), 1'b0);
      else if (c <= 12)
        send(1'b0, 4'd0, 32'h8000_0500, 1'b0);
      else
        wr_valid_i = 1'b0;
      if (c == 4) chk("bp_ready_c4", 64'(wr_ready_o), 64'(1));
      if (c == 5) begin
        chk("bp_pend_c5", 64'(pending_o), 64'(4));
        chk("bp_ready_c5", 64'(wr_ready_o), 64'(0));
      end
      if (c == 11) chk("bp_ready_c11", 64'(wr_ready_o), 64'(0));
      if (c == 12) begin
        chk("bp_pend_c12", 64'(pending_o), 64'(3));
        chk("bp_ready_c12", 64'(wr_ready_o), 64'(1));
      end
      if (c == 13) begin
        chk("bp_pend_c13", 64'(pending_o), 64'(4));
        chk("bp_ready_c13", 64'(wr_ready_o), 64'(0));
      end
      if (c >= 4 && c < 52) begin
        chk("bp_en", 64'(dfi_wrdata_en_o), 64'(1));
        chk("bp_data", 64'(dfi_wrdata_o),
            64'(32'h8000_0000 + 32'(((c - 4) / 8) * 256)
                + 32'((c - 4) % 8)));
        chk("bp_late", 64'(late_o),
            64'(((c - 4) % 8 == 0) && (c >= 12)));
      end
      if (c == 52) begin
        expect_idle("bp");
        chk("bp_busy_end", 64'(busy_o), 64'(0));
      end
      tick();
    end

    // reset during beat 3 with one burst still queued
    send(1'b0, 4'd0, 32'h6000_0000, 1'b0);
    tick();
    send(1'b0, 4'd0, 32'h6100_0000, 1'b0);
    tick();
    wr_valid_i = 1'b0;
    repeat (5) tick();
    chk("rmid_data_b3", 64'(dfi_wrdata_o), 64'(32'h6000_0003));
    chk("rmid_pend", 64'(pending_o), 64'(1));
    #2 rst_ni = 1'b0;
    #1;
    expect_idle("rmid");
    chk("rmid_pend0", 64'(pending_o), 64'(0));
    chk("rmid_busy0", 64'(busy_o), 64'(0));
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    tick();
    chk("rmid_ready", 64'(wr_ready_o), 64'(1));
    expect_idle("rmid_post");
    send(1'b1, 4'd4, 32'h7000_0000, 1'b1);
    tick();
    wr_valid_i = 1'b0;
    tick();
    tick();
    tick();
    expect_burst("rnew", 4, 32'h7000_0000, 1'b0, 1'b1);
    expect_idle("rnew");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
